// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM encoding, line levels and counter sizing.
// Used by the transmitter today and by the receiver side of the link.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Baud timer: counts clocks while enabled and pulses tick on the last clock of each bit period.
// Held at zero while disabled so every bit period starts aligned to the enable edge.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, stop bit.
// Every output is decoded from registered state, so valid/data_in never reach an output combinationally.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output state_t           fsm_state
);

  // Handshake: a word is taken on any rising edge where valid && ready (outside reset).
  // ready is high only in IDLE, so valid raised during a frame is simply ignored.

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             tick;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (valid) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && (bit_cnt == LAST_BIT)) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    serial_out = LINE_IDLE;
    case (state)
      IDLE:    serial_out = LINE_IDLE;
      START:   serial_out = START_BIT;
      DATA:    serial_out = shift_reg[0];
      STOP:    serial_out = STOP_BIT;
      default: serial_out = LINE_IDLE;
    endcase
  end

  assign ready     = (state == IDLE);
  assign busy      = !ready;
  assign done      = (state == STOP) && tick;
  assign fsm_state = state;

endmodule
